// File: rtl/control_unit.sv
// control_unit: Moore FSM sequencing fetch/decode/execute for the 16-bit processor
module control_unit #(
    parameter logic [2:0] ALU_PASS = 3'b000,
    parameter logic [2:0] ALU_ADD  = 3'b001,
    parameter logic [2:0] ALU_SUB  = 3'b010
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [15:0] IR,
    output logic        PC_clr,
    output logic        PC_up,
    output logic        IR_ld,
    output logic [7:0]  D_addr,
    output logic        D_wr,
    output logic        RF_s,
    output logic [3:0]  RF_W_addr,
    output logic        RF_W_wr,
    output logic [3:0]  RF_Ra_addr,
    output logic        RF_Ra_rd,
    output logic [3:0]  RF_Rb_addr,
    output logic        RF_Rb_rd,
    output logic [2:0]  ALU_s0,
    output logic [3:0]  OutState
);
    localparam logic [3:0] S_INIT   = 4'd0;
    localparam logic [3:0] S_FETCH  = 4'd1;
    localparam logic [3:0] S_DECODE = 4'd2;
    localparam logic [3:0] S_NOOP   = 4'd3;
    localparam logic [3:0] S_LOADA  = 4'd4;
    localparam logic [3:0] S_LOADB  = 4'd5;
    localparam logic [3:0] S_STORE  = 4'd6;
    localparam logic [3:0] S_ADD    = 4'd7;
    localparam logic [3:0] S_SUB    = 4'd8;
    localparam logic [3:0] S_HALT   = 4'd9;

    logic [3:0] state, next;
    logic       load, arith, store;

    always_ff @(posedge Clk)
        state <= Reset ? S_INIT : next;

    always_comb begin
        next = S_INIT;
        case (state)
            S_INIT:   next = S_FETCH;
            S_FETCH:  next = S_DECODE;
            S_DECODE:
                case (IR[15:12])
                    4'h1:    next = S_STORE;
                    4'h2:    next = S_LOADA;
                    4'h3:    next = S_ADD;
                    4'h4:    next = S_SUB;
                    4'h5:    next = S_HALT;
                    default: next = S_NOOP;
                endcase
            S_NOOP, S_LOADB, S_STORE, S_ADD, S_SUB: next = S_FETCH;
            S_LOADA:  next = S_LOADB;
            S_HALT:   next = S_HALT;
            default:  next = S_INIT;
        endcase
    end

    always_comb begin
        load       = state == S_LOADA || state == S_LOADB;
        arith      = state == S_ADD || state == S_SUB;
        store      = state == S_STORE;
        PC_clr     = state == S_INIT;
        PC_up      = state == S_FETCH;
        IR_ld      = state == S_FETCH;
        D_addr     = load ? IR[11:4] : store ? IR[7:0] : 8'd0;
        D_wr       = store;
        RF_s       = load;
        RF_W_addr  = (load || arith) ? IR[3:0] : 4'd0;
        RF_W_wr    = state == S_LOADB || arith;
        RF_Ra_addr = (store || arith) ? IR[11:8] : 4'd0;
        RF_Ra_rd   = store || arith;
        RF_Rb_addr = arith ? IR[7:4] : 4'd0;
        RF_Rb_rd   = arith;
        ALU_s0     = state == S_ADD ? ALU_ADD : state == S_SUB ? ALU_SUB : ALU_PASS;
        OutState   = state;
    end
endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: scoreboard bench comparing every cycle's state and outputs against expected vectors
module tb_control_unit;
    logic        Clk = 0;
    logic        Reset = 1;
    logic [15:0] IR = '0;
    logic        PC_clr, PC_up, IR_ld, D_wr, RF_s, RF_W_wr, RF_Ra_rd, RF_Rb_rd;
    logic [7:0]  D_addr;
    logic [3:0]  RF_W_addr, RF_Ra_addr, RF_Rb_addr, OutState;
    logic [2:0]  ALU_s0;
    logic [34:0] obs;
    logic [34:0] q[$];
    int checks = 0;
    int errors = 0;

    control_unit dut (
        .Clk(Clk), .Reset(Reset), .IR(IR),
        .PC_clr(PC_clr), .PC_up(PC_up), .IR_ld(IR_ld),
        .D_addr(D_addr), .D_wr(D_wr), .RF_s(RF_s),
        .RF_W_addr(RF_W_addr), .RF_W_wr(RF_W_wr),
        .RF_Ra_addr(RF_Ra_addr), .RF_Ra_rd(RF_Ra_rd),
        .RF_Rb_addr(RF_Rb_addr), .RF_Rb_rd(RF_Rb_rd),
        .ALU_s0(ALU_s0), .OutState(OutState)
    );

    always #5 Clk = ~Clk;

    assign obs = {OutState, PC_clr, PC_up, IR_ld, D_addr, D_wr, RF_s, RF_W_addr, RF_W_wr,
                  RF_Ra_addr, RF_Ra_rd, RF_Rb_addr, RF_Rb_rd, ALU_s0};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected outputs for a given state, written out from the instruction formats
    function automatic logic [34:0] ev(input logic [3:0] s, input logic [15:0] ir);
        logic pc_clr = 0, pc_up = 0, ir_ld = 0, d_wr = 0, rf_s = 0, w_wr = 0, ra_rd = 0, rb_rd = 0;
        logic [7:0] d_addr = 0;
        logic [3:0] w_addr = 0, ra = 0, rb = 0;
        logic [2:0] alu = 3'b000;
        case (s)
            4'd0: pc_clr = 1;
            4'd1: begin pc_up = 1; ir_ld = 1; end
            4'd4: begin d_addr = ir[11:4]; rf_s = 1; w_addr = ir[3:0]; end
            4'd5: begin d_addr = ir[11:4]; rf_s = 1; w_addr = ir[3:0]; w_wr = 1; end
            4'd6: begin d_addr = ir[7:0]; d_wr = 1; ra = ir[11:8]; ra_rd = 1; end
            4'd7, 4'd8: begin
                ra = ir[11:8]; rb = ir[7:4]; w_addr = ir[3:0];
                ra_rd = 1; rb_rd = 1; w_wr = 1;
                alu = s == 4'd7 ? 3'b001 : 3'b010;
            end
            default: ;
        endcase
        return {s, pc_clr, pc_up, ir_ld, d_addr, d_wr, rf_s, w_addr, w_wr,
                ra, ra_rd, rb, rb_rd, alu};
    endfunction

    task automatic step(input logic rst, input logic [15:0] ir, input logic [3:0] s);
        @(negedge Clk);
        Reset = rst;
        IR = ir;
        q.push_back(ev(s, ir));
    endtask

    always @(posedge Clk) begin
        logic [34:0] e;
        #1;
        if (q.size() != 0) begin
            e = q.pop_front();
            check("state", 64'(OutState), 64'(e[34:31]));
            check("outputs", 64'(obs), 64'(e));
            check("wr_excl", 64'(D_wr & RF_W_wr), 64'd0);
        end
    end

    initial begin
        step(1, 16'h0000, 0);
        step(1, 16'h0000, 0);
        step(0, 16'h2A35, 1);
        step(0, 16'h2A35, 2);
        step(0, 16'h2A35, 4);
        step(0, 16'h2A35, 5);
        step(0, 16'h2A35, 1);
        step(0, 16'h17F0, 2);
        step(0, 16'h17F0, 6);
        step(0, 16'h3124, 1);
        step(0, 16'h3124, 2);
        step(0, 16'h3124, 7);
        step(0, 16'h4124, 1);
        step(0, 16'h4124, 2);
        step(0, 16'h4124, 8);
        step(0, 16'hE123, 1);
        step(0, 16'hE123, 2);
        step(0, 16'hE123, 3);
        step(0, 16'h0000, 1);
        step(0, 16'h0000, 2);
        step(0, 16'h0000, 3);
        step(0, 16'h2A35, 1);
        step(0, 16'h2A35, 2);
        step(0, 16'h2A35, 4);
        step(1, 16'h2A35, 0);
        step(0, 16'h5000, 1);
        step(0, 16'h5000, 2);
        for (int i = 0; i < 20; i++) step(0, 16'h5000, 9);
        step(1, 16'h5000, 0);
        step(0, 16'h5000, 1);
        repeat (3) @(negedge Clk);
        check("drain", 64'(q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
- Moore FSM controller for the 16-bit processor.
- Sequences fetch, decode and execute for NOOP, STORE, LOAD, ADD, SUB and HALT.
- Drives the program counter, instruction register, data memory, register file and ALU.
- Generates RF_s, the select for the 16-bit 2:1 mux feeding register-file write data: 0 = ALU result, 1 = data-memory read data.

Parameters:
- ALU_PASS, 3'b000, ALU select value driven when no ALU op is active.
- ALU_ADD, 3'b001, ALU select value for ADD.
- ALU_SUB, 3'b010, ALU select value for SUB.

Ports:
- Clk  input  1  system clock; all state changes on rising edge.
- Reset  input  1  synchronous, active-high reset.
- IR  input  16  current instruction register contents.
- PC_clr  output  1  clear program counter.
- PC_up  output  1  increment program counter.
- IR_ld  output  1  load instruction register from instruction memory.
- D_addr  output  8  data-memory address.
- D_wr  output  1  data-memory write enable.
- RF_s  output  1  register-file write-data mux select (0 ALU, 1 memory).
- RF_W_addr  output  4  register-file write address.
- RF_W_wr  output  1  register-file write enable.
- RF_Ra_addr  output  4  read port A address.
- RF_Ra_rd  output  1  read port A enable.
- RF_Rb_addr  output  4  read port B address.
- RF_Rb_rd  output  1  read port B enable.
- ALU_s0  output  3  ALU operation select.
- OutState  output  4  current state encoding, for debug display.

Behaviour:
- One clock (Clk). Reset is synchronous and active-high: sampled on the rising edge of Clk, next state is Init from any state, including Halt and mid-Load.
- Outputs are combinational decodes of the state register plus IR fields (Moore; no IR-dependent output in Init/Fetch/Decode). No glitch-free requirement.
- Default for every output in every state unless listed below: 0; ALU_s0 = ALU_PASS.
- State encodings (OutState):
  - Init = 0, Fetch = 1, Decode = 2, Noop = 3
  - LoadA = 4, LoadB = 5, Store = 6
  - Add = 7, Sub = 8, Halt = 9
- Reset/Init output values: PC_clr = 1, all others default.
- Instruction formats:
  - opcode = IR[15:12]
  - LOAD 0010: D_addr = IR[11:4], Rw = IR[3:0]
  - STORE 0001: Ra = IR[11:8], D_addr = IR[7:0]
  - ADD 0011 / SUB 0100: Ra = IR[11:8], Rb = IR[7:4], Rw = IR[3:0]
  - NOOP 0000, HALT 0101
- Transitions and outputs:
  - Init: PC_clr = 1 -> Fetch.
  - Fetch: IR_ld = 1, PC_up = 1 -> Decode.
  - Decode: no active outputs. Next state by opcode: 0000 Noop, 0001 Store, 0010 LoadA, 0011 Add, 0100 Sub, 0101 Halt, 0110-1111 Noop (illegal opcodes are silently ignored).
  - Noop: -> Fetch.
  - LoadA: D_addr = IR[11:4], RF_s = 1, RF_W_addr = IR[3:0], RF_W_wr = 0 -> LoadB. This cycle covers the synchronous memory read latency.
  - LoadB: same as LoadA plus RF_W_wr = 1 -> Fetch.
  - Store: D_addr = IR[7:0], D_wr = 1, RF_Ra_addr = IR[11:8], RF_Ra_rd = 1 -> Fetch.
  - Add: RF_Ra_addr = IR[11:8], RF_Rb_addr = IR[7:4], RF_Ra_rd = RF_Rb_rd = 1, RF_W_addr = IR[3:0], RF_W_wr = 1, RF_s = 0, ALU_s0 = ALU_ADD -> Fetch.
  - Sub: same as Add with ALU_s0 = ALU_SUB -> Fetch.
  - Halt: default outputs; stays in Halt until Reset.
- Latency per instruction, counted from the Fetch cycle:
  - NOOP, STORE, ADD, SUB: 3 cycles.
  - LOAD: 4 cycles.
  - HALT: terminal.
- Exactly one PC_up pulse per instruction; PC_clr is asserted only in Init.
- RF_W_wr and D_wr are never asserted in the same cycle.
- IR changes while outside Fetch are the datapath's responsibility; the controller decodes the current IR value combinationally.
- Illegal state-register values (10-15) -> Init on the next edge.

Test Plan:
- Reset high 2 cycles, then low -> OutState = 0 with PC_clr = 1; next edges give OutState 1 (IR_ld = 1, PC_up = 1), then 2.
- IR = 16'h2A35 (LOAD) -> after Decode: LoadA with D_addr = 8'hA3, RF_s = 1, RF_W_addr = 5, RF_W_wr = 0; then LoadB with RF_W_wr = 1; then Fetch.
- IR = 16'h17F0 (STORE) -> Store state: D_addr = 8'hF0, D_wr = 1, RF_Ra_addr = 7, RF_Ra_rd = 1, RF_W_wr = 0; then Fetch.
- IR = 16'h3124 then 16'h4124 -> Add state then Sub state: Ra = 1, Rb = 2, Rw = 4, RF_W_wr = 1, RF_s = 0; ALU_s0 = 3'b001 for Add, 3'b010 for Sub.
- IR = 16'h5000 -> Halt (OutState 9) held for 20 cycles with PC_up = 0; Reset pulse -> Init, PC_clr = 1.
- IR = 16'hE123 (illegal) -> Decode goes to Noop, no writes; assert Reset during LoadA -> next state Init with no RF_W_wr pulse.
